// File: rtl/regfile_sb.sv
// Decode-stage register file with write-through bypass, per-register pending
// bits for hazard detection and a post-reset zeroing sweep of every register.
module regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      busy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic                alloc_stall
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     idx_reg, idx_next;
  logic [NREG-1:0]   pending_reg, pending_next;
  logic [XLEN-1:0]   mem [NREG];

  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [XLEN-1:0]   mem_wd;
  logic              run;
  logic              stall_raw;

  // Outputs are forced inactive in the reset cycle itself, whatever the state.
  assign run   = (state_reg == RUN) && !reset;
  assign ready = run;

  assign stall_raw = alloc_en && (alloc_addr != '0) && pending_reg[alloc_addr]
                     && !(we && (wa == alloc_addr));
  assign alloc_stall = run ? stall_raw : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= INIT;
      idx_reg     <= '0;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      pending_reg <= pending_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    pending_next = pending_reg;
    mem_we       = 1'b0;
    mem_wa       = wa;
    mem_wd       = wd;
    case (state_reg)
      INIT: begin
        mem_we   = 1'b1;
        mem_wa   = idx_reg;
        mem_wd   = '0;
        idx_next = idx_reg + 1'b1;
        if (idx_reg == AW'(NREG - 1)) state_next = RUN;
      end
      RUN: begin
        if (we && (wa != '0)) begin
          mem_we           = 1'b1;
          pending_next[wa] = 1'b0;
        end
        // Applied after the writeback clear so a new producer wins.
        if (alloc_en && !stall_raw && (alloc_addr != '0))
          pending_next[alloc_addr] = 1'b1;
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_wa] <= mem_wd;
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            pend;

    assign addr = ra[gi*AW +: AW];

    always_comb begin
      data = '0;
      pend = 1'b0;
      if (run && (addr != '0)) begin
        if (we && (wa == addr)) begin
          data = wd;
        end else begin
          data = mem[addr];
          pend = pending_reg[addr];
        end
      end
    end

    assign rd[gi*XLEN +: XLEN] = data;
    assign busy[gi]            = pend;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default instance plus a 3-port 32-bit 16-entry one.
module tb_regfile_sb;

  logic         clk;
  logic         reset, ready, we, alloc_en, alloc_stall;
  logic [9:0]   ra;
  logic [127:0] rd;
  logic [1:0]   busy;
  logic [4:0]   wa, alloc_addr;
  logic [63:0]  wd;

  logic         reset2, ready2, we2, alloc_en2, alloc_stall2;
  logic [11:0]  ra2;
  logic [95:0]  rd2;
  logic [2:0]   busy2;
  logic [3:0]   wa2, alloc_addr2;
  logic [31:0]  wd2;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_sb u_dut (
    .clk(clk), .reset(reset), .ready(ready), .ra(ra), .rd(rd), .busy(busy),
    .we(we), .wa(wa), .wd(wd), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .alloc_stall(alloc_stall)
  );

  regfile_sb #(.XLEN(32), .NREG(16), .NRD(3)) u_small (
    .clk(clk), .reset(reset2), .ready(ready2), .ra(ra2), .rd(rd2), .busy(busy2),
    .we(we2), .wa(wa2), .wd(wd2), .alloc_en(alloc_en2), .alloc_addr(alloc_addr2),
    .alloc_stall(alloc_stall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    ra = {5'd31, 5'd5};
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c <= 32; c++) begin
      alloc_en = 1'b1;
      alloc_addr = 5'd4;
      #1;
      n_cmp++;
      if (ready !== (c >= 32)) begin
        n_bad++; $display("FAIL sweep_ready c=%0d got=%b exp=%b", c, ready, c >= 32);
      end
      n_cmp++;
      if (rd !== 128'd0) begin n_bad++; $display("FAIL sweep_rd c=%0d got=%h exp=0", c, rd); end
      n_cmp++;
      if (alloc_stall !== (c < 32)) begin
        n_bad++; $display("FAIL sweep_stall c=%0d got=%b exp=%b", c, alloc_stall, c < 32);
      end
      alloc_en = 1'b0;
      $display("sweep cycle %0d ready=%b stall=%b", c, ready, alloc_stall);
      @(negedge clk);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd5; wd = 64'hDEAD_BEEF_0000_0001; ra = {5'd0, 5'd5};
    #1;
    n_cmp++;
    if (rd[63:0] !== 64'hDEAD_BEEF_0000_0001) begin
      n_bad++; $display("FAIL bypass_rd got=%h exp=deadbeef00000001", rd[63:0]);
    end
    $display("bypass write r5 rd0=%h", rd[63:0]);
    @(negedge clk);
    we = 1'b0;
    #1;
    n_cmp++;
    if (rd[63:0] !== 64'hDEAD_BEEF_0000_0001) begin
      n_bad++; $display("FAIL persist_rd got=%h exp=deadbeef00000001", rd[63:0]);
    end
    n_cmp++;
    if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL persist_busy got=%b exp=0", busy[0]); end
    $display("read back r5 rd0=%h", rd[63:0]);
    @(negedge clk);
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wa = 5'd0; wd = 64'h1234; ra = {5'd0, 5'd0};
    #1;
    n_cmp++;
    if (rd[63:0] !== 64'd0) begin n_bad++; $display("FAIL zero_bypass got=%h exp=0", rd[63:0]); end
    @(negedge clk);
    we = 1'b0; alloc_en = 1'b1; alloc_addr = 5'd0;
    #1;
    n_cmp++;
    if (rd[63:0] !== 64'd0) begin n_bad++; $display("FAIL zero_read got=%h exp=0", rd[63:0]); end
    n_cmp++;
    if (alloc_stall !== 1'b0) begin n_bad++; $display("FAIL zero_alloc_stall got=%b exp=0", alloc_stall); end
    @(negedge clk);
    alloc_en = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 2'b00) begin n_bad++; $display("FAIL zero_busy got=%b exp=00", busy); end
    $display("r0 write/alloc rd0=%h busy=%b", rd[63:0], busy);
    @(negedge clk);
  endtask

  task automatic test_pending();
    ra = {5'd7, 5'd0};
    alloc_en = 1'b1; alloc_addr = 5'd7;
    #1;
    n_cmp++;
    if (alloc_stall !== 1'b0) begin n_bad++; $display("FAIL pend_first_stall got=%b exp=0", alloc_stall); end
    @(negedge clk);
    #1;
    n_cmp++;
    if (busy[1] !== 1'b1) begin n_bad++; $display("FAIL pend_busy got=%b exp=1", busy[1]); end
    n_cmp++;
    if (alloc_stall !== 1'b1) begin n_bad++; $display("FAIL pend_realloc_stall got=%b exp=1", alloc_stall); end
    $display("alloc r7 busy1=%b realloc stall=%b", busy[1], alloc_stall);
    @(negedge clk);
    we = 1'b1; wa = 5'd7; wd = 64'h42;
    #1;
    n_cmp++;
    if (alloc_stall !== 1'b0) begin n_bad++; $display("FAIL wr_alloc_stall got=%b exp=0", alloc_stall); end
    n_cmp++;
    if (rd[127:64] !== 64'h42) begin n_bad++; $display("FAIL wr_alloc_rd got=%h exp=42", rd[127:64]); end
    n_cmp++;
    if (busy[1] !== 1'b0) begin n_bad++; $display("FAIL wr_alloc_bypass_busy got=%b exp=0", busy[1]); end
    @(negedge clk);
    we = 1'b0; alloc_en = 1'b0;
    #1;
    n_cmp++;
    if (busy[1] !== 1'b1) begin n_bad++; $display("FAIL wr_alloc_busy_after got=%b exp=1", busy[1]); end
    n_cmp++;
    if (rd[127:64] !== 64'h42) begin n_bad++; $display("FAIL wr_alloc_rd_after got=%h exp=42", rd[127:64]); end
    $display("write+alloc r7 rd1=%h busy1=%b", rd[127:64], busy[1]);
    @(negedge clk);
    we = 1'b1; wa = 5'd7; wd = 64'h43;
    @(negedge clk);
    we = 1'b0;
    #1;
    n_cmp++;
    if (busy[1] !== 1'b0) begin n_bad++; $display("FAIL retire_busy got=%b exp=0", busy[1]); end
    n_cmp++;
    if (rd[127:64] !== 64'h43) begin n_bad++; $display("FAIL retire_rd got=%h exp=43", rd[127:64]); end
    $display("retire r7 rd1=%h busy1=%b", rd[127:64], busy[1]);
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    // Alloc 3 and write 10 in one cycle, then alloc 9.
    alloc_en = 1'b1; alloc_addr = 5'd3; we = 1'b1; wa = 5'd10; wd = 64'h77;
    @(negedge clk);
    alloc_addr = 5'd9; we = 1'b0;
    @(negedge clk);
    alloc_en = 1'b0; ra = {5'd9, 5'd3};
    #1;
    n_cmp++;
    if (busy !== 2'b11) begin n_bad++; $display("FAIL mid_pend_busy got=%b exp=11", busy); end
    ra = {5'd10, 5'd3};
    #1;
    n_cmp++;
    if (rd[127:64] !== 64'h77) begin n_bad++; $display("FAIL indep_write_rd got=%h exp=77", rd[127:64]); end
    @(negedge clk);
    reset = 1'b1; we = 1'b1; wa = 5'd3; wd = 64'h99; alloc_en = 1'b1; alloc_addr = 5'd5;
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ready got=%b exp=0", ready); end
    @(negedge clk);
    reset = 1'b0; we = 1'b0; alloc_en = 1'b0; ra = {5'd9, 5'd3};
    for (int c = 0; c <= 32; c++) begin
      #1;
      n_cmp++;
      if (ready !== (c >= 32)) begin
        n_bad++; $display("FAIL mid_sweep_ready c=%0d got=%b exp=%b", c, ready, c >= 32);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (rd !== 128'd0) begin n_bad++; $display("FAIL mid_after_rd got=%h exp=0", rd); end
    n_cmp++;
    if (busy !== 2'b00) begin n_bad++; $display("FAIL mid_after_busy got=%b exp=00", busy); end
    ra = {5'd10, 5'd5};
    #1;
    n_cmp++;
    if (rd !== 128'd0) begin n_bad++; $display("FAIL mid_after_rd2 got=%h exp=0", rd); end
    $display("after mid reset rd=%h busy=%b", rd, busy);
    @(negedge clk);
  endtask

  task automatic test_small();
    @(negedge clk);
    reset2 = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      #1;
      n_cmp++;
      if (ready2 !== (c >= 16)) begin
        n_bad++; $display("FAIL small_sweep_ready c=%0d got=%b exp=%b", c, ready2, c >= 16);
      end
      @(negedge clk);
    end
    we2 = 1'b1; wa2 = 4'd1; wd2 = 32'hA;
    @(negedge clk);
    wa2 = 4'd2; wd2 = 32'hB;
    @(negedge clk);
    wa2 = 4'd15; wd2 = 32'hF;
    @(negedge clk);
    we2 = 1'b0; ra2 = {4'd15, 4'd2, 4'd1};
    #1;
    n_cmp++;
    if (rd2 !== {32'hF, 32'hB, 32'hA}) begin
      n_bad++; $display("FAIL small_rd got=%h exp=0000000f0000000b0000000a", rd2);
    end
    n_cmp++;
    if (busy2 !== 3'b000) begin n_bad++; $display("FAIL small_busy got=%b exp=000", busy2); end
    $display("small read rd2=%h", rd2);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; ra = '0; we = 1'b0; wa = '0; wd = '0; alloc_en = 1'b0; alloc_addr = '0;
    reset2 = 1'b1; ra2 = '0; we2 = 1'b0; wa2 = '0; wd2 = '0; alloc_en2 = 1'b0; alloc_addr2 = '0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_pending();
    test_mid_reset();
    test_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
